mips_multicycle_ctrl: RTL and testbench

Multicycle MIPS main controller, the control-side counterpart of the datapath ALU. Sequences each instruction through fetch/decode/execute/memory/writeback states. Drives the datapath enables and the 3-bit ALUControl code, and consumes the ALU Zero flag to resolve beq.

---
 rtl/mips_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller.
// Steps each instruction through FETCH/DECODE/execute/memory/writeback and
// drives the datapath enables, mux selects and the 3-bit ALUControl code.
// beq is resolved through PCEn using the ALU Zero flag in the BEQ state.
module mips_multicycle_ctrl #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       IllegalOp,
    output logic       Halted
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_BAD = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEX  = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIX   = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] funct_alu;
    logic       funct_ok;
    logic       pcwrite;
    logic       branch;

    // Funct field decode for R-type; unsupported codes map to the unused ALU op
    always_comb begin
        funct_alu = ALU_BAD;
        funct_ok  = 1'b1;
        case (Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and Moore outputs; reset forces every output low
    always_comb begin
        state_nxt  = state;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        PCSrc      = 2'b00;
        IllegalOp  = 1'b0;
        Halted     = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        PCEn       = 1'b0;

        case (state)
            S_FETCH: begin
                IRWrite    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                pcwrite    = 1'b1;
                state_nxt  = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPEX;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_ADDI:      state_nxt = S_ADDIX;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        IllegalOp = 1'b1;
                        state_nxt = ILLEGAL_TRAP ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_nxt  = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD      = 1'b1;
                state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg  = 1'b1;
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_RTYPEX: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
                state_nxt  = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                // Unsupported Funct silently suppresses the register write
                RegDst     = 1'b1;
                ALUControl = funct_alu;
                RegWrite   = funct_ok;
                state_nxt  = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_ADDIX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_nxt  = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite  = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                PCSrc     = 2'b10;
                pcwrite   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                Halted    = 1'b1;
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase

        PCEn = pcwrite | (branch & Zero);

        if (reset) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUControl = 3'b000;
            PCSrc      = 2'b00;
            PCEn       = 1'b0;
            IllegalOp  = 1'b0;
            Halted     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Testbench for mips_multicycle_ctrl: two instances (ILLEGAL_TRAP 0 and 1)
// share stimulus; each cycle the expected output vectors are queued and a
// monitor on the falling edge pops and compares them.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b1;
    logic       reset;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;

    logic       iord0, memw0, irw0, rdst0, mtr0, rw0, sa0, pe0, ill0, hlt0;
    logic [1:0] sb0, ps0;
    logic [2:0] ac0;
    logic       iord1, memw1, irw1, rdst1, mtr1, rw1, sa1, pe1, ill1, hlt1;
    logic [1:0] sb1, ps1;
    logic [2:0] ac1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(iord0), .MemWrite(memw0), .IRWrite(irw0), .RegDst(rdst0),
        .MemtoReg(mtr0), .RegWrite(rw0), .ALUSrcA(sa0), .ALUSrcB(sb0),
        .ALUControl(ac0), .PCSrc(ps0), .PCEn(pe0), .IllegalOp(ill0),
        .Halted(hlt0)
    );

    mips_multicycle_ctrl #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .IorD(iord1), .MemWrite(memw1), .IRWrite(irw1), .RegDst(rdst1),
        .MemtoReg(mtr1), .RegWrite(rw1), .ALUSrcA(sa1), .ALUSrcB(sb1),
        .ALUControl(ac1), .PCSrc(ps1), .PCEn(pe1), .IllegalOp(ill1),
        .Halted(hlt1)
    );

    logic [16:0] o0, o1;
    assign o0 = {iord0, memw0, irw0, rdst0, mtr0, rw0, sa0, sb0, ac0, ps0, pe0, ill0, hlt0};
    assign o1 = {iord1, memw1, irw1, rdst1, mtr1, rw1, sa1, sb1, ac1, ps1, pe1, ill1, hlt1};

    function automatic logic [16:0] mk(input logic iord, input logic memw,
                                       input logic irw, input logic rdst,
                                       input logic mtr, input logic rw,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic [1:0] ps,
                                       input logic pe, input logic ill,
                                       input logic hlt);
        return {iord, memw, irw, rdst, mtr, rw, sa, sb, ac, ps, pe, ill, hlt};
    endfunction

    // Hand-derived per-state output vectors
    logic [16:0] e_zero, e_fetch, e_dec, e_dec_ill, e_memadr, e_memrd, e_memwb;
    logic [16:0] e_memwr, e_addiwb, e_jump, e_halt;
    initial begin
        e_zero    = '0;
        e_fetch   = mk(0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 1, 0, 0);
        e_dec     = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 0, 0);
        e_dec_ill = mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0, 1, 0);
        e_memadr  = mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0, 0, 0);
        e_memrd   = mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
        e_memwb   = mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
        e_memwr   = mk(1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
        e_addiwb  = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
        e_jump    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 0, 0);
        e_halt    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 1);
    end

    logic [5:0] rt_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
    logic [2:0] rt_ac [6] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b011};
    logic       rt_rw [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    typedef struct {
        string       name;
        logic [16:0] e0;
        logic [16:0] e1;
    } exp_t;
    exp_t sbq[$];

    // Queue the expectation for the current cycle, then advance one clock
    task automatic cyc(input string nm, input logic [16:0] e0, input logic [16:0] e1);
        exp_t t;
        t.name = nm;
        t.e0   = e0;
        t.e1   = e1;
        sbq.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare both instances against the queued expectation
    always @(negedge clk) begin : mon
        exp_t t;
        if (sbq.size() > 0) begin
            t = sbq.pop_front();
            checks++;
            if (o0 !== t.e0) begin
                errors++;
                $display("FAIL %s trap0 got %h expected %h", t.name, o0, t.e0);
            end
            checks++;
            if (o1 !== t.e1) begin
                errors++;
                $display("FAIL %s trap1 got %h expected %h", t.name, o1, t.e1);
            end
        end
    end

    initial begin
        reset = 1'b1;
        Op    = 6'b100011;
        Funct = 6'b000000;
        Zero  = 1'b0;

        // Reset held three cycles: everything low
        for (int i = 0; i < 3; i++) cyc("reset", e_zero, e_zero);
        reset = 1'b0;

        // lw
        cyc("lw_fetch", e_fetch, e_fetch);
        cyc("lw_decode", e_dec, e_dec);
        cyc("lw_memadr", e_memadr, e_memadr);
        cyc("lw_memrd", e_memrd, e_memrd);
        cyc("lw_memwb", e_memwb, e_memwb);

        // R-type sweep including an unsupported Funct
        for (int i = 0; i < 6; i++) begin
            Op    = 6'b000000;
            Funct = rt_fn[i];
            cyc("rt_fetch", e_fetch, e_fetch);
            cyc("rt_decode", e_dec, e_dec);
            cyc("rt_x", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, rt_ac[i], 2'b00, 0, 0, 0),
                        mk(0, 0, 0, 0, 0, 0, 1, 2'b00, rt_ac[i], 2'b00, 0, 0, 0));
            cyc("rt_wb", mk(0, 0, 0, 1, 0, rt_rw[i], 0, 2'b00, rt_ac[i], 2'b00, 0, 0, 0),
                         mk(0, 0, 0, 1, 0, rt_rw[i], 0, 2'b00, rt_ac[i], 2'b00, 0, 0, 0));
        end

        // beq taken, Zero toggled during DECODE
        Op = 6'b000100;
        Zero = 1'b0;
        cyc("beq_fetch", e_fetch, e_fetch);
        Zero = 1'b1;
        cyc("beq_decode_z", e_dec, e_dec);
        cyc("beq_taken", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 1, 0, 0),
                         mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 1, 0, 0));
        // beq not taken
        Zero = 1'b0;
        cyc("beq2_fetch", e_fetch, e_fetch);
        Zero = 1'b1;
        cyc("beq2_decode_z", e_dec, e_dec);
        Zero = 1'b0;
        cyc("beq_not_taken", mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 0, 0),
                             mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0, 0, 0));

        // addi
        Op = 6'b001000;
        cyc("addi_fetch", e_fetch, e_fetch);
        cyc("addi_decode", e_dec, e_dec);
        cyc("addi_x", e_memadr, e_memadr);
        cyc("addi_wb", e_addiwb, e_addiwb);

        // j
        Op = 6'b000010;
        cyc("j_fetch", e_fetch, e_fetch);
        cyc("j_decode", e_dec, e_dec);
        cyc("j_jump", e_jump, e_jump);

        // sw complete
        Op = 6'b101011;
        cyc("sw_fetch", e_fetch, e_fetch);
        cyc("sw_decode", e_dec, e_dec);
        cyc("sw_memadr", e_memadr, e_memadr);
        cyc("sw_memwr", e_memwr, e_memwr);

        // sw abandoned by reset in MEMADR: MemWrite must never rise
        cyc("sw2_fetch", e_fetch, e_fetch);
        cyc("sw2_decode", e_dec, e_dec);
        reset = 1'b1;
        cyc("sw2_memadr_rst", e_zero, e_zero);
        reset = 1'b0;
        cyc("sw2_after_rst", e_fetch, e_fetch);

        // Illegal opcode: trap0 returns to FETCH, trap1 halts
        Op = 6'b111111;
        cyc("ill_decode", e_dec_ill, e_dec_ill);
        for (int k = 0; k < 12; k++) begin
            Zero = k[0];
            cyc("ill_after", (k % 2 == 0) ? e_fetch : e_dec_ill, e_halt);
        end
        reset = 1'b1;
        cyc("halt_reset", e_zero, e_zero);
        reset = 1'b0;
        Op = 6'b100011;
        cyc("halt_cleared_fetch", e_fetch, e_fetch);
        cyc("halt_cleared_decode", e_dec, e_dec);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
